apb_master: RTL and testbench

APB requester (master) that turns a simple valid/ready command interface into single APB3 read/write transfers toward the 16-entry byte-wide APB slave. It sits between a local controller or testbench driver and the APB bus. It runs the IDLE/SETUP/ACCESS phase sequencing, tolerates any number of slave wait states, and aborts hung transfers with a timeout. Each transfer returns exactly one response pulse carrying read data and error status.

---
 rtl/apb_master.sv | 140 ++++++++++++++
 tb/tb_apb_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB3 requester: converts a valid/ready command into one APB transfer.
// It returns one response pulse per command and aborts a transfer whose wait states reach TIMEOUT.
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t              state_reg, state_next;
    logic [7:0]          wait_cnt_reg, wait_cnt_next, wait_inc;
    logic                psel_reg, psel_next;
    logic                penable_reg, penable_next;
    logic                pwrite_reg, pwrite_next;
    logic [ADDR_W-1:0]   paddr_reg, paddr_next;
    logic [DATA_W-1:0]   pwdata_reg, pwdata_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic                rsp_err_reg, rsp_err_next;
    logic                rsp_timeout_reg, rsp_timeout_next;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg       <= ST_IDLE;
            wait_cnt_reg    <= '0;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            pwrite_reg      <= 1'b0;
            paddr_reg       <= '0;
            pwdata_reg      <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            psel_reg        <= psel_next;
            penable_reg     <= penable_next;
            pwrite_reg      <= pwrite_next;
            paddr_reg       <= paddr_next;
            pwdata_reg      <= pwdata_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    // Saturating so a stuck slave can never wrap the counter back below TIMEOUT.
    assign wait_inc = (wait_cnt_reg == 8'hFF) ? 8'hFF : wait_cnt_reg + 8'd1;

    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        psel_next        = psel_reg;
        penable_next     = penable_reg;
        pwrite_next      = pwrite_reg;
        paddr_next       = paddr_reg;
        pwdata_next      = pwdata_reg;
        rsp_valid_next   = 1'b0;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_err_next     = rsp_err_reg;
        rsp_timeout_next = rsp_timeout_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    pwrite_next  = cmd_write;
                    paddr_next   = cmd_addr;
                    pwdata_next  = cmd_wdata;
                    psel_next    = 1'b1;
                    penable_next = 1'b0;
                    state_next   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_next  = 1'b1;
                wait_cnt_next = '0;
                state_next    = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_rdata_next   = pwrite_reg ? '0 : PRDATA;
                    rsp_err_next     = PSLVERR;
                    rsp_timeout_next = 1'b0;
                    state_next       = ST_IDLE;
                end else begin
                    wait_cnt_next = wait_inc;
                    if (wait_inc >= TIMEOUT_CNT) begin
                        psel_next        = 1'b0;
                        penable_next     = 1'b0;
                        rsp_valid_next   = 1'b1;
                        rsp_rdata_next   = '0;
                        rsp_err_next     = 1'b1;
                        rsp_timeout_next = 1'b1;
                        state_next       = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cmd_ready   = (state_reg == ST_IDLE);
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign PSEL        = psel_reg;
    assign PENABLE     = penable_reg;
    assign PWRITE      = pwrite_reg;
    assign PADDR       = paddr_reg;
    assign PWDATA      = pwdata_reg;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: configurable APB slave, vector table, random traffic against a reference model.
// It also runs hand sequences for back-to-back commands and a reset asserted in the middle of a transfer.
module tb_apb_master;
    localparam int T = 16;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0, cmd_wdata = '0;
    logic       cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic       PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [7:0] PADDR, PWDATA, PRDATA;

    int checks = 0;
    int errors = 0;

    // slave configuration
    int         cfg_wait = 1;
    bit         cfg_err = 0, cfg_sready = 0, cfg_ovr = 0;
    logic [7:0] cfg_ovr_val = '0;
    int         acc = 0;
    logic [7:0] mem [16] = '{default: 8'h00};
    logic [7:0] ref_mem [16] = '{default: 8'h00};

    always #5 PCLK = ~PCLK;

    apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(T)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // Slave: ready after cfg_wait low ACCESS cycles; optional early PREADY in SETUP.
    assign PREADY  = (PSEL && PENABLE && acc >= cfg_wait) || (cfg_sready && PSEL && !PENABLE);
    assign PRDATA  = cfg_ovr ? cfg_ovr_val : mem[PADDR[3:0]];
    assign PSLVERR = cfg_err;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE) begin
            acc <= PREADY ? 0 : acc + 1;
            if (PREADY && PWRITE && !cfg_err) mem[PADDR[3:0]] <= PWDATA;
        end else begin
            acc <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         w;
        bit         serr;
        bit         sready;
        bit         ovr;
        logic [7:0] ovr_val;
        logic [7:0] exp_rdata;
        bit         exp_err;
        bit         exp_to;
        int         exp_lat;
    } vec_t;

    // One complete transfer. Latency counts the cycles from acceptance until rsp_valid is seen.
    task automatic xfer(input vec_t v, input string tag);
        int lat, pcnt;
        bit stable, got;
        logic [7:0] held;
        @(negedge PCLK);
        cfg_wait = v.w; cfg_err = v.serr; cfg_sready = v.sready;
        cfg_ovr = v.ovr; cfg_ovr_val = v.ovr_val;
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        check({tag, ":ready"}, 32'(cmd_ready), 32'd1);
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0; cmd_write = ~v.wr; cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
        lat = 0; pcnt = 0; stable = 1; got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge PCLK);
            lat++;
            if (PSEL) begin
                pcnt++;
                if (PADDR !== v.addr || PWRITE !== v.wr || PWDATA !== v.wdata) stable = 0;
            end
            if (rsp_valid === 1'b1) begin
                got = 1;
                break;
            end
        end
        check({tag, ":rsp_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, ":rdata"}, 32'(rsp_rdata), 32'(v.exp_rdata));
            check({tag, ":err"}, 32'(rsp_err), 32'(v.exp_err));
            check({tag, ":timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
            check({tag, ":latency"}, 32'(lat), 32'(v.exp_lat));
            check({tag, ":psel_cycles"}, 32'(pcnt), 32'(v.exp_lat - 1));
            check({tag, ":stable"}, 32'(stable), 32'd1);
            held = rsp_rdata;
            @(negedge PCLK);
            check({tag, ":pulse"}, 32'(rsp_valid), 32'd0);
            check({tag, ":hold"}, 32'(rsp_rdata), 32'(held));
        end
        $display("XFER %s wr=%0d addr=%02h wdata=%02h wait=%0d rdata=%02h err=%0d to=%0d lat=%0d",
                 tag, v.wr, v.addr, v.wdata, v.w, rsp_rdata, rsp_err, rsp_timeout, lat);
    endtask

    vec_t tbl [10];

    initial begin
        vec_t v;
        int n;
        bit prev_psel;
        logic [7:0] b2b_val [4];

        tbl[0] = '{1'b1, 8'h03, 8'hA5, 1,   1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4};
        tbl[1] = '{1'b0, 8'h03, 8'h00, 1,   1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 4};
        tbl[2] = '{1'b0, 8'h03, 8'h11, 5,   1'b0, 1'b0, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b0, 8};
        tbl[3] = '{1'b0, 8'h09, 8'h00, 255, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 18};
        tbl[4] = '{1'b1, 8'h05, 8'h5A, 0,   1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3};
        tbl[5] = '{1'b0, 8'h05, 8'h00, 0,   1'b1, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0, 3};
        tbl[6] = '{1'b0, 8'h03, 8'h00, 2,   1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 5};
        tbl[7] = '{1'b1, 8'h07, 8'h77, 1,   1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 4};
        tbl[8] = '{1'b0, 8'h07, 8'h00, 1,   1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4};
        tbl[9] = '{1'b0, 8'h05, 8'h00, 3,   1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0, 6};

        // reset state
        repeat (2) @(negedge PCLK);
        check("rst:psel", 32'(PSEL), 32'd0);
        check("rst:penable", 32'(PENABLE), 32'd0);
        check("rst:bus", {7'd0, PWRITE, PADDR, PWDATA, 8'd0}, 32'd0);
        check("rst:rsp", {6'd0, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, 9'd0}, 32'd0);
        check("rst:cmd_ready", 32'(cmd_ready), 32'd1);
        PRESETn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            xfer(tbl[i], $sformatf("vec%0d", i));
            if (tbl[i].wr && !tbl[i].exp_err) ref_mem[tbl[i].addr[3:0]] = tbl[i].wdata;
        end

        // random traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            v.wr = 1'($urandom); v.addr = 8'($urandom); v.wdata = 8'($urandom);
            v.w = $urandom_range(0, 20); v.serr = ($urandom_range(0, 7) == 0);
            v.sready = 1'($urandom); v.ovr = 0; v.ovr_val = 0;
            if (v.w >= T) begin
                v.exp_rdata = 0; v.exp_err = 1; v.exp_to = 1; v.exp_lat = 2 + T;
            end else begin
                v.exp_rdata = v.wr ? 8'h00 : ref_mem[v.addr[3:0]];
                v.exp_err = v.serr; v.exp_to = 0; v.exp_lat = 3 + v.w;
                if (v.wr && !v.serr) ref_mem[v.addr[3:0]] = v.wdata;
            end
            xfer(v, $sformatf("rnd%0d", i));
        end

        // back-to-back writes with cmd_valid held high
        b2b_val = '{8'h11, 8'h22, 8'h33, 8'h44};
        @(negedge PCLK);
        cfg_wait = 1; cfg_err = 0; cfg_sready = 0; cfg_ovr = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_write = 1'b1; cmd_addr = 8'(i); cmd_wdata = b2b_val[i];
            n = 0;
            prev_psel = PSEL;
            while (!cmd_ready && n < 20) begin
                prev_psel = PSEL;
                @(negedge PCLK);
                n++;
            end
            check($sformatf("b2b%0d:ready", i), 32'(cmd_ready), 32'd1);
            if (i > 0) begin
                check($sformatf("b2b%0d:rsp_at_accept", i), 32'(rsp_valid), 32'd1);
                check($sformatf("b2b%0d:psel_gap", i), {prev_psel, PSEL}, 32'b10);
            end
            @(posedge PCLK);
            @(negedge PCLK);
            check($sformatf("b2b%0d:psel_rise", i), 32'(PSEL), 32'd1);
            $display("XFER b2b%0d wr=1 addr=%02h wdata=%02h accepted", i, i, b2b_val[i]);
            ref_mem[i] = b2b_val[i];
        end
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        check("b2b:last_rsp", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b:mem%0d", i), 32'(mem[i]), 32'(b2b_val[i]));
        for (int i = 0; i < 4; i++) begin
            v = '{1'b0, 8'(i), 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h00, b2b_val[i], 1'b0, 1'b0, 4};
            xfer(v, $sformatf("b2b_rd%0d", i));
        end

        // reset asserted in the middle of ACCESS
        @(negedge PCLK);
        cfg_wait = 10;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h02;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (!PENABLE && n < 10) begin
            @(negedge PCLK);
            n++;
        end
        check("rstmid:in_access", 32'(PENABLE), 32'd1);
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        check("rstmid:psel", 32'(PSEL), 32'd0);
        check("rstmid:penable", 32'(PENABLE), 32'd0);
        check("rstmid:rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        check("rstmid:cmd_ready", 32'(cmd_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge PCLK);
            if (rsp_valid) n++;
        end
        check("rstmid:no_rsp", 32'(n), 32'd0);
        $display("XFER rstmid rd addr=02 abandoned rsp_count=%0d", n);
        v = '{1'b0, 8'h03, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h00, ref_mem[3], 1'b0, 1'b0, 4};
        xfer(v, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
